// File: rtl/clock_enable_monitor_pkg.sv
// Shared types and widths for the clock-enable monitor.
package clock_enable_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} mon_state_t;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/clock_enable_monitor_period_cnt.sv
// Elapsed-cycle counter between enable strobes: period value, measurement and timeout strobes.
module enable_period_cnt
  import clock_enable_monitor_pkg::*;
#(
  parameter int RATIO = 50,
  parameter int TOL   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W:0]   o_p,
  output logic             o_meas,
  output logic             o_timeout
);

  localparam logic [CNT_W:0]   P_ONE     = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   TIMEOUT_P = (CNT_W + 1)'(RATIO + 1 + TOL);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Period is one more than the cycles counted since the last strobe.
  assign o_p       = {1'b0, cnt_q} + P_ONE;
  assign o_meas    = i_en;
  assign o_timeout = !i_en && (o_p == TIMEOUT_P);

endmodule

// File: rtl/clock_enable_monitor.sv
// Enable-strobe period monitor: lock FSM and registered status outputs.
// Optional error statistics counter enabled by CLOCK_ENABLE_MONITOR_STATS_EN.
module clock_enable_monitor
  import clock_enable_monitor_pkg::*;
#(
  parameter int RATIO    = 50,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [CNT_W-1:0]     o_period,
  output logic                 o_period_vld
`ifdef CLOCK_ENABLE_MONITOR_STATS_EN
  ,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

  localparam int               GCNT_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GCNT_W-1:0] GCNT_ONE = GCNT_W'(1);
  localparam logic [GCNT_W-1:0] LOCK_M1  = GCNT_W'(LOCK_CNT - 1);
  localparam int               P_LO     = RATIO + 1 - TOL;
  localparam int               P_HI     = RATIO + 1 + TOL;

  logic [CNT_W:0] p;
  logic           meas;
  logic           timeout;
  logic           good;

  enable_period_cnt #(
    .RATIO (RATIO),
    .TOL   (TOL),
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .o_p       (p),
    .o_meas    (meas),
    .o_timeout (timeout)
  );

  assign good = (int'(p) >= P_LO) && (int'(p) <= P_HI);

  mon_state_t        state_q, state_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              vld_q, vld_d;

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    err_d    = 1'b0;
    vld_d    = 1'b0;
    period_d = period_q;
    case (state_q)
      IDLE: begin
        // First strobe only arms the counter; there is no period to measure yet.
        if (meas) begin
          state_d = ACQ;
          gcnt_d  = '0;
        end
      end
      ACQ: begin
        if (meas) begin
          period_d = p[CNT_W-1:0];
          vld_d    = 1'b1;
          if (good) begin
            gcnt_d = gcnt_q + GCNT_ONE;
            if (gcnt_q == LOCK_M1) begin
              state_d = LOCKED;
            end
          end else begin
            err_d  = 1'b1;
            gcnt_d = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (meas) begin
          period_d = p[CNT_W-1:0];
          vld_d    = 1'b1;
          if (!good) begin
            err_d   = 1'b1;
            gcnt_d  = '0;
            state_d = ACQ;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gcnt_d  = '0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gcnt_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign o_locked     = locked_q;
  assign o_err        = err_q;
  assign o_period     = period_q;
  assign o_period_vld = vld_q;

`ifdef CLOCK_ENABLE_MONITOR_STATS_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_clock_enable_monitor.sv
// Self-checking bench for clock_enable_monitor: timestamp-based reference model plus directed checks.
module tb_clock_enable_monitor;

  localparam int RATIO    = 50;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_en = 1'b0;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_period;
  logic             o_period_vld;
  logic [15:0]      o_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_enable_monitor #(
    .RATIO    (RATIO),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .o_locked     (o_locked),
    .o_err        (o_err),
    .o_period     (o_period),
    .o_period_vld (o_period_vld)
`ifdef CLOCK_ENABLE_MONITOR_STATS_EN
    ,
    .o_err_cnt    (o_err_cnt)
`endif
  );

`ifndef CLOCK_ENABLE_MONITOR_STATS_EN
  assign o_err_cnt = 16'h0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the timestamp of the last strobe and a run of good periods.
  int  m_cyc = 0;
  int  m_last = 0;
  bit  m_tracking = 0;
  bit  m_locked = 0;
  int  m_run = 0;
  bit  m_err = 0;
  bit  m_vld = 0;
  int  m_period = 0;
  int  m_errcnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      m_cyc++;
      if (!rst) begin
        m_last = m_cyc; m_tracking = 0; m_locked = 0; m_run = 0;
        m_err = 0; m_vld = 0; m_period = 0; m_errcnt = 0;
      end else begin
        int elapsed;
        elapsed = m_cyc - m_last;
        m_err = 0;
        m_vld = 0;
        if (i_en) begin
          if (!m_tracking) begin
            m_tracking = 1;
            m_run = 0;
          end else begin
            m_period = elapsed % 256;
            m_vld = 1;
            if ((elapsed - (RATIO + 1) <= TOL) && ((RATIO + 1) - elapsed <= TOL)) begin
              if (!m_locked) begin
                m_run++;
                if (m_run == LOCK_CNT) m_locked = 1;
              end
            end else begin
              m_err = 1; m_locked = 0; m_run = 0;
            end
          end
          m_last = m_cyc;
        end else if (m_tracking && elapsed == RATIO + 1 + TOL) begin
          m_err = 1; m_tracking = 0; m_locked = 0;
        end
        if (m_err && m_errcnt < 16'hFFFF) m_errcnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_period", int'(o_period), 0);
        chk("rst_vld", int'(o_period_vld), 0);
      end else begin
        chk("locked", int'(o_locked), int'(m_locked));
        chk("err", int'(o_err), int'(m_err));
        chk("vld", int'(o_period_vld), int'(m_vld));
        chk("period", int'(o_period), m_period);
`ifdef CLOCK_ENABLE_MONITOR_STATS_EN
        chk("err_cnt", int'(o_err_cnt), m_errcnt);
`endif
      end
    end
  end

  // Drive i_en for n edges; returns #1 after the last edge.
  task automatic tick(input bit en, input int n);
    for (int i = 0; i < n; i++) begin
      i_en = en;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_gap(input int g);
    tick(1'b0, g - 1);
    tick(1'b1, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_locked", int'(o_locked), 0);
    chk("lit_reset_period", int'(o_period), 0);
    rst = 1'b1;
    $display("txn reset released");

    tick(1'b1, 1);
    chk("lit_first_pulse_vld", int'(o_period_vld), 0);
    $display("txn first pulse");
    for (int k = 0; k < 4; k++) begin
      pulse_gap(51);
      chk("lit_nominal_vld", int'(o_period_vld), 1);
      chk("lit_nominal_period", int'(o_period), 51);
      chk("lit_lock_state", int'(o_locked), (k == 3) ? 1 : 0);
      $display("txn period 51 pulse %0d locked=%0d", k + 2, o_locked);
    end

    pulse_gap(49);
    chk("lit_short_period", int'(o_period), 49);
    chk("lit_short_err", int'(o_err), 1);
    chk("lit_short_unlock", int'(o_locked), 0);
    $display("txn period 49 err=%0d locked=%0d", o_err, o_locked);
    for (int k = 0; k < 4; k++) pulse_gap(51);
    chk("lit_relock", int'(o_locked), 1);
    $display("txn relock locked=%0d", o_locked);

    pulse_gap(50);
    chk("lit_gap50_err", int'(o_err), 0);
    pulse_gap(52);
    chk("lit_gap52_err", int'(o_err), 0);
    chk("lit_gap52_locked", int'(o_locked), 1);
    chk("lit_gap52_period", int'(o_period), 52);
    $display("txn tolerant gaps 50/52 locked=%0d", o_locked);

    tick(1'b0, 51);
    chk("lit_pre_timeout_err", int'(o_err), 0);
    chk("lit_pre_timeout_locked", int'(o_locked), 1);
    tick(1'b0, 1);
    chk("lit_timeout_err", int'(o_err), 1);
    chk("lit_timeout_locked", int'(o_locked), 0);
    $display("txn timeout err=%0d locked=%0d", o_err, o_locked);
    tick(1'b0, 5);
    tick(1'b1, 1);
    chk("lit_restart_vld", int'(o_period_vld), 0);
    $display("txn restart pulse vld=%0d", o_period_vld);

    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1);
      chk("lit_held_period", int'(o_period), 1);
      chk("lit_held_err", int'(o_err), 1);
      chk("lit_held_locked", int'(o_locked), 0);
      $display("txn held-high edge %0d period=%0d err=%0d", k, o_period, o_err);
    end

    for (int k = 0; k < 4; k++) pulse_gap(51);
    chk("lit_lock_before_reset", int'(o_locked), 1);
    tick(1'b0, 10);
    #2 rst = 1'b0;
    #1;
    chk("lit_async_locked", int'(o_locked), 0);
    chk("lit_async_period", int'(o_period), 0);
    chk("lit_async_vld", int'(o_period_vld), 0);
    chk("lit_async_err", int'(o_err), 0);
    $display("txn async reset mid-locked locked=%0d period=%0d", o_locked, o_period);
    @(posedge clk);
    #1 rst = 1'b1;

    tick(1'b1, 1);
    tick(1'b1, 3);
    tick(1'b0, 1);
`ifdef CLOCK_ENABLE_MONITOR_STATS_EN
    chk("lit_err_cnt3", int'(o_err_cnt), 3);
    #2 rst = 1'b0;
    #1 chk("lit_err_cnt_rst", int'(o_err_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;
`endif
    $display("txn three mismatches err_cnt=%0d", o_err_cnt);
    tick(1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_enable_monitor.md
# clock_enable_monitor

Checks a periodic clock-enable strobe against its expected period and reports lock status, period mismatches and the last measured period. It sits downstream of the clock-enable generators, on the consumer side of each strobe. It flags drifted, missing or stuck enables before they corrupt rate-dependent logic.

## Interface
- RATIO, 50: expected strobe period is RATIO+1 clk cycles, matching the generator's RATIO.
- TOL, 1: allowed deviation in cycles; a period P is good when |P − (RATIO+1)| ≤ TOL.
- LOCK_CNT, 4: consecutive good periods required to declare lock.
- CNT_W, 8: width of the period counter; must satisfy RATIO+1+TOL < 2^CNT_W.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, no other reset.
- i_en  input  1  enable strobe under test, synchronous to clk.
- o_locked  output  1  high while in LOCKED.
- o_err  output  1  one-cycle pulse per mismatch or timeout.
- o_period  output  CNT_W  last measured period, held until the next measurement.
- o_period_vld  output  1  one-cycle pulse when o_period updates.

## Operation
- cnt is the elapsed-cycle counter.
  - Edge with i_en=1: cnt←0.
  - Otherwise cnt←cnt+1, saturating at 2^CNT_W−1.
- Measurement happens on an edge with i_en=1 while in ACQ or LOCKED.
  - P = cnt+1, computed at CNT_W+1 bits.
  - o_period←P[CNT_W-1:0]; o_period_vld pulses.
- Timeout: an edge with i_en=0 where cnt+1 == RATIO+1+TOL, in ACQ or LOCKED.
- FSM states IDLE, ACQ, LOCKED; good-period counter gcnt.
  - IDLE, pulse → ACQ, gcnt←0. No measurement and no o_period_vld for this pulse.
  - ACQ, good P → gcnt+1. When it reaches LOCK_CNT → LOCKED.
  - ACQ, bad P → o_err, gcnt←0, stay in ACQ.
  - LOCKED, good P → stay.
  - LOCKED, bad P → o_err, ACQ, gcnt←0.
  - ACQ/LOCKED, timeout → o_err, IDLE. The next pulse restarts acquisition.
- i_en held high: each edge measures P=1. This is bad unless RATIO+1−TOL ≤ 1.
- Reset values: all outputs 0, cnt 0, gcnt 0, state IDLE.
  - Reset asserted mid-operation clears everything immediately.
  - The first pulse after release is treated as a first pulse.

## Timing
- All outputs registered. For an event sampled at edge N, the outputs reflect it after edge N:
  - o_period, o_period_vld, o_err;
  - o_locked rising on the LOCK_CNT-th good period;
  - o_locked falling on a bad period or timeout.
- Latency from i_en to outputs: 1 cycle.
- o_err and o_period_vld pulse together on a bad measurement.
- Timeout fires exactly RATIO+1+TOL edges after the last pulse, with no pulse at that edge.
- o_err is never high on two consecutive edges, except for back-to-back bad measurements.

## Configuration
- CLOCK_ENABLE_MONITOR_STATS_EN defined:
  - adds output port o_err_cnt [15:0];
  - o_err_cnt increments on every o_err pulse and saturates at 16'hFFFF;
  - reset to 0 only by rst.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package clock_enable_monitor_pkg holds:
  - typedef enum logic [1:0] mon_state_t {IDLE, ACQ, LOCKED};
  - localparam ERR_CNT_W = 16.
- One sub-module, enable_period_cnt. It contains the saturating cnt, the P computation and the timeout compare, and outputs P, meas and timeout strobes.
- The top holds the FSM, gcnt, the output registers and the optional stats counter.

## Test plan
- Pulses every 51 cycles (RATIO=50, TOL=1, LOCK_CNT=4):
  - o_period=51 with o_period_vld on pulses 2..5;
  - o_locked rises 1 cycle after the 5th pulse;
  - o_err never asserts.
- Locked, then one gap of 49 cycles:
  - o_period=49, o_err pulse, o_locked falls the same cycle;
  - relock after 4 further 51-cycle periods.
- Gaps of 50 and 52 (within TOL) while locked: no o_err, o_locked stays high.
- Locked, then pulses stop:
  - o_err pulses and o_locked falls after the 52nd edge past the last pulse;
  - state IDLE; the next pulse produces no o_period_vld.
- i_en held high in ACQ: o_period=1 and o_err every cycle; o_locked stays 0.
- Async reset asserted mid-LOCKED, between edges: all outputs 0 immediately.
  - With CLOCK_ENABLE_MONITOR_STATS_EN: 3 mismatches give o_err_cnt=3; reset returns it to 0.
